// File: rtl/iir_coef_loader_pkg.sv
// Shared definitions for the IIR coefficient loader: FSM encoding, Q1.15 constants
// and the coefficient address map.
package iir_coef_loader_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PENDING = 2'd1,
        ST_APPLY   = 2'd2,
        ST_FLUSH   = 2'd3
    } state_t;

    localparam logic signed [15:0] ONE = 16'sh7FFF;

    // a[k] lives at A_BASE+k, b[k] at b_base(N_order)+k
    localparam logic [4:0] A_BASE = 5'd0;

    function automatic logic [4:0] b_base(input int n_order);
        return 5'(n_order);
    endfunction

endpackage

// File: rtl/iir_coef_loader_coef_bank.sv
// Register file of 2*N_order coefficients with single-entry write, whole-bank load
// and a packed read-out (entry k at bits [(k+1)*Width-1 : k*Width]).
module coef_bank #(
    parameter int N_order = 4,
    parameter int Width   = 16
) (
    input  logic                         i_clkp,
    input  logic                         i_rstn,
    input  logic                         i_we,
    input  logic [3:0]                   i_waddr,
    input  logic [Width-1:0]             i_wdata,
    input  logic                         i_load,
    input  logic [2*N_order*Width-1:0]   i_load_data,
    output logic [2*N_order*Width-1:0]   o_data
);

    localparam int N_ENT = 2 * N_order;

    logic [Width-1:0] mem_q [N_ENT];

    // A whole-bank load wins over a single-entry write
    always_ff @(posedge i_clkp or negedge i_rstn) begin
        if (!i_rstn) begin
            for (int k = 0; k < N_ENT; k++) mem_q[k] <= '0;
        end else if (i_load) begin
            for (int k = 0; k < N_ENT; k++) mem_q[k] <= i_load_data[k*Width +: Width];
        end else if (i_we) begin
            for (int k = 0; k < N_ENT; k++) begin
                if (i_waddr == 4'(k)) mem_q[k] <= i_wdata;
            end
        end
    end

    always_comb begin
        o_data = '0;
        for (int k = 0; k < N_ENT; k++) o_data[k*Width +: Width] = mem_q[k];
    end

endmodule

// File: rtl/iir_coef_loader.sv
// Double-buffered IIR coefficient loader: writes land in a shadow bank, a commit copies
// shadow to active on the next filter sample boundary, then the filter history is flushed.
module iir_coef_loader
    import iir_coef_loader_pkg::*;
#(
    parameter int N_order      = 4,
    parameter int Width        = 16,
    parameter int Flush_Cycles = 8
) (
    input  logic                       i_clkp,
    input  logic                       i_rstn,
    input  logic                       i_wr_valid,
    output logic                       o_wr_ready,
    input  logic [3:0]                 i_wr_addr,
    input  logic signed [Width-1:0]    i_wr_data,
    input  logic                       i_commit,
    input  logic                       i_sync,
    output logic [Width*N_order-1:0]   o_factor_a,
    output logic [Width*N_order-1:0]   o_factor_b,
    output logic                       o_filter_rstn,
    output logic                       o_busy,
    output logic                       o_updated,
    output logic                       o_addr_err
);

    localparam int         TOT_W      = 2 * N_order * Width;
    localparam int         CNT_W      = $clog2(Flush_Cycles + 1);
    localparam logic [4:0] ADDR_LIMIT = 5'(2 * b_base(N_order));

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                alive_q;
    logic                addr_err_q;
    logic                wr_fire;
    logic                addr_ok;
    logic                bank_load;
    logic [TOT_W-1:0]    shadow_data;
    logic [TOT_W-1:0]    active_data;

    assign addr_ok   = {1'b0, i_wr_addr} < ADDR_LIMIT;
    assign wr_fire   = i_wr_valid && o_wr_ready;
    assign bank_load = (state_q == ST_APPLY);

    // alive_q keeps ready/filter-enable low while reset is held and lifts them on the first edge after
    always_ff @(posedge i_clkp or negedge i_rstn) begin
        if (!i_rstn) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            alive_q    <= 1'b0;
            addr_err_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            alive_q <= 1'b1;
            if (wr_fire && !addr_ok) addr_err_q <= 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            ST_IDLE: begin
                if (i_commit) state_d = ST_PENDING;
            end
            ST_PENDING: begin
                if (i_sync) state_d = ST_APPLY;
            end
            ST_APPLY: begin
                cnt_d   = CNT_W'(Flush_Cycles - 1);
                state_d = ST_FLUSH;
            end
            ST_FLUSH: begin
                if (cnt_q == '0) state_d = ST_IDLE;
                else             cnt_d   = cnt_q - 1'b1;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign o_wr_ready    = alive_q && (state_q == ST_IDLE);
    assign o_filter_rstn = alive_q && (state_q != ST_FLUSH);
    assign o_busy        = (state_q != ST_IDLE);
    assign o_updated     = bank_load;
    assign o_addr_err    = addr_err_q;

    coef_bank #(
        .N_order (N_order),
        .Width   (Width)
    ) u_shadow (
        .i_clkp      (i_clkp),
        .i_rstn      (i_rstn),
        .i_we        (wr_fire && addr_ok),
        .i_waddr     (i_wr_addr),
        .i_wdata     (i_wr_data),
        .i_load      (1'b0),
        .i_load_data ({TOT_W{1'b0}}),
        .o_data      (shadow_data)
    );

    coef_bank #(
        .N_order (N_order),
        .Width   (Width)
    ) u_active (
        .i_clkp      (i_clkp),
        .i_rstn      (i_rstn),
        .i_we        (1'b0),
        .i_waddr     (4'd0),
        .i_wdata     ({Width{1'b0}}),
        .i_load      (bank_load),
        .i_load_data (shadow_data),
        .o_data      (active_data)
    );

    assign o_factor_a = active_data[Width*N_order-1:0];
    assign o_factor_b = active_data[TOT_W-1:Width*N_order];

endmodule
